evt_coalesce: RTL and testbench

EVT_COALESCE -- requirements
Module: evt_coalesce

---
 rtl/evt_coalesce.sv | 129 ++++++++++++
 tb/tb_evt_coalesce.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_coalesce.sv
// evt_coalesce: interrupt coalescing for a stream of event strobes.
// Pending events are counted until a threshold is reached or a timeout
// expires, then irq is held until acknowledged.
// Define EVT_COALESCE_TIMER_EN to build the timeout timer. Without it,
// firing is threshold-only and the timeout input is unused.
module evt_coalesce #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             evt,
    input  logic [CNT_W-1:0] threshold,
    input  logic [TMO_W-1:0] timeout,
    input  logic             irq_ack,
    output logic             irq,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [CNT_W-1:0] ack_cnt,
    output logic [31:0]      total_cnt
);

    typedef enum logic [1:0] {StIdle, StPend, StFire} state_t;

    state_t           state;
    logic             acc;
    logic             thr_le1;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W-1:0] pend_inc;
    logic [CNT_W-1:0] pend_step;
    logic             tmo_hit;

    assign acc       = evt & en;
    // A threshold of 0 is treated as 1.
    assign thr_le1   = (threshold <= CNT_W'(1));
    assign thr_eff   = thr_le1 ? CNT_W'(1) : threshold;
    assign pend_inc  = (&pend_cnt) ? pend_cnt : pend_cnt + CNT_W'(1);
    assign pend_step = acc ? pend_inc : pend_cnt;

`ifdef EVT_COALESCE_TIMER_EN
    logic [TMO_W-1:0] timer;

    assign tmo_hit = (timeout != '0) && (timer == timeout - TMO_W'(1));

    // Timer counts cycles spent in PEND, holds in FIRE, clears on ack/flush.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer <= '0;
        end else if (!en) begin
            timer <= '0;
        end else begin
            case (state)
                StIdle:  timer <= '0;
                StPend:  timer <= timer + TMO_W'(1);
                StFire:  if (irq_ack) timer <= '0;
                default: timer <= '0;
            endcase
        end
    end
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign unused_timeout = ^timeout;
`endif

    // Coalescing FSM with registered irq, plus the event/ack counters.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= StIdle;
            irq       <= 1'b0;
            pend_cnt  <= '0;
            ack_cnt   <= '0;
            total_cnt <= '0;
        end else if (!en) begin
            state    <= StIdle;
            irq      <= 1'b0;
            pend_cnt <= '0;
        end else begin
            if (acc) begin
                total_cnt <= total_cnt + 32'd1;
            end
            case (state)
                StIdle: begin
                    if (acc) begin
                        pend_cnt <= CNT_W'(1);
                        if (thr_le1) begin
                            state <= StFire;
                            irq   <= 1'b1;
                        end else begin
                            state <= StPend;
                        end
                    end
                end
                StPend: begin
                    pend_cnt <= pend_step;
                    if ((pend_step >= thr_eff) || tmo_hit) begin
                        state <= StFire;
                        irq   <= 1'b1;
                    end
                end
                StFire: begin
                    if (irq_ack) begin
                        // Captured count excludes any same-cycle event.
                        ack_cnt  <= pend_cnt;
                        pend_cnt <= acc ? CNT_W'(1) : '0;
                        if (!acc) begin
                            state <= StIdle;
                            irq   <= 1'b0;
                        end else if (thr_le1) begin
                            state <= StFire;
                            irq   <= 1'b1;
                        end else begin
                            state <= StPend;
                            irq   <= 1'b0;
                        end
                    end else begin
                        pend_cnt <= pend_step;
                    end
                end
                default: begin
                    state <= StIdle;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evt_coalesce.sv
// tb_evt_coalesce: scenario tasks push expected observations to a queue
// as stimulus is driven and pop/compare them after the clock edge.
module tb_evt_coalesce;

`ifdef EVT_COALESCE_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    typedef struct packed {
        logic        irq;
        logic [15:0] pend;
        logic [15:0] ack;
        logic [31:0] total;
    } obs_t;

    typedef struct packed {
        logic        irq;
        logic [3:0]  pend;
        logic [3:0]  ack;
        logic [31:0] total;
    } obs4_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        en;
    logic        evt;
    logic [15:0] threshold;
    logic [15:0] timeout;
    logic        irq_ack;

    logic        irq;
    logic [15:0] pend_cnt;
    logic [15:0] ack_cnt;
    logic [31:0] total_cnt;
    logic        irq4;
    logic [3:0]  pend4;
    logic [3:0]  ack4;
    logic [31:0] total4;

    obs_t  cur;
    obs4_t cur4;
    obs_t  e;
    obs4_t e4;
    obs_t  sb[$];
    obs4_t sb4[$];

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] ack_exp = '0;
    logic [31:0] tot_exp = '0;

    assign cur  = {irq, pend_cnt, ack_cnt, total_cnt};
    assign cur4 = {irq4, pend4, ack4, total4};

    evt_coalesce #(.CNT_W(16), .TMO_W(16)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .evt       (evt),
        .threshold (threshold),
        .timeout   (timeout),
        .irq_ack   (irq_ack),
        .irq       (irq),
        .pend_cnt  (pend_cnt),
        .ack_cnt   (ack_cnt),
        .total_cnt (total_cnt)
    );

    evt_coalesce #(.CNT_W(4), .TMO_W(16)) dut4 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .evt       (evt),
        .threshold (threshold[3:0]),
        .timeout   (timeout),
        .irq_ack   (irq_ack),
        .irq       (irq4),
        .pend_cnt  (pend4),
        .ack_cnt   (ack4),
        .total_cnt (total4)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        sb.push_back('0);
        e = sb.pop_front();
        checks++;
        if (cur !== e) begin
            errors++;
            $display("FAIL reset: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                     cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
        end
    endtask

    task automatic test_threshold();
        threshold = 16'd4; timeout = 16'd0; en = 1'b1; irq_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            evt = (i % 3 == 0);
            if (evt) tot_exp++;
            sb.push_back({1'(i >= 9), 16'(i / 3 + 1), ack_exp, tot_exp});
            tick();
            e = sb.pop_front();
            checks++;
            if (cur !== e) begin
                errors++;
                $display("FAIL threshold[%0d]: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                         i, cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
            end
        end
        // Acknowledge in FIRE, then a stray acknowledge in IDLE.
        evt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            irq_ack = 1'b1;
            if (i == 0) ack_exp = 16'd4;
            sb.push_back({1'b0, 16'd0, ack_exp, tot_exp});
            tick();
            irq_ack = 1'b0;
            e = sb.pop_front();
            checks++;
            if (cur !== e) begin
                errors++;
                $display("FAIL ack[%0d]: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                         i, cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
            end
        end
    endtask

    task automatic test_timeout();
        threshold = 16'd100; timeout = 16'd20;
        for (int i = 0; i <= 21; i++) begin
            evt = (i == 0);
            irq_ack = (i == 21);
            if (evt) tot_exp++;
            if (i == 21 && TMR) begin
                ack_exp = 16'd1;
                sb.push_back({1'b0, 16'd0, ack_exp, tot_exp});
            end else if (i == 21) begin
                sb.push_back({1'b0, 16'd1, ack_exp, tot_exp});
            end else begin
                sb.push_back({1'(TMR && i >= 20), 16'd1, ack_exp, tot_exp});
            end
            tick();
            e = sb.pop_front();
            checks++;
            if (cur !== e) begin
                errors++;
                $display("FAIL timeout[%0d]: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                         i, cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
            end
        end
        irq_ack = 1'b0;
        en = 1'b0;
        sb.push_back({1'b0, 16'd0, ack_exp, tot_exp});
        tick();
        en = 1'b1;
        e = sb.pop_front();
        checks++;
        if (cur !== e) begin
            errors++;
            $display("FAIL timeout_flush: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                     cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
        end
    endtask

    task automatic test_en_flush();
        logic [15:0] pend_exp [5] = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd1};
        logic        en_seq   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic        evt_seq  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        threshold = 16'd10; timeout = 16'd0;
        for (int i = 0; i < 5; i++) begin
            en  = en_seq[i];
            evt = evt_seq[i];
            if (en && evt) tot_exp++;
            sb.push_back({1'b0, pend_exp[i], ack_exp, tot_exp});
            tick();
            e = sb.pop_front();
            checks++;
            if (cur !== e) begin
                errors++;
                $display("FAIL en_flush[%0d]: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                         i, cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
            end
        end
        evt = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_back_to_back();
        // Steps: flush, 5 events, ack+evt, idle, 2 events, then threshold 0 cases.
        logic        en_seq  [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        logic        evt_seq [14] = '{0, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 1, 0};
        logic        ack_seq [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
        logic [15:0] thr_seq [14] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0, 0, 0, 0};
        logic        irq_exp [14] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1};
        logic [15:0] pnd_exp [14] = '{0, 1, 2, 3, 4, 5, 1, 1, 2, 3, 1, 0, 1, 1};
        logic [15:0] ack_seq_exp [14] = '{0, 0, 0, 0, 0, 0, 5, 5, 5, 5, 3, 1, 1, 1};
        timeout = 16'd0;
        for (int i = 0; i < 14; i++) begin
            en = en_seq[i]; evt = evt_seq[i]; irq_ack = ack_seq[i]; threshold = thr_seq[i];
            if (en && evt) tot_exp++;
            if (i >= 6) ack_exp = ack_seq_exp[i];
            sb.push_back({irq_exp[i], pnd_exp[i], ack_exp, tot_exp});
            tick();
            e = sb.pop_front();
            checks++;
            if (cur !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                         i, cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
            end
        end
        irq_ack = 1'b0;
        evt = 1'b0;
    endtask

    task automatic test_async_reset();
        // Left in FIRE by the previous scenario; reset lands mid-cycle.
        #2;
        sys_rst_n = 1'b0;
        #1;
        ack_exp = '0; tot_exp = '0;
        sb.push_back('0);
        e = sb.pop_front();
        checks++;
        if (cur !== e) begin
            errors++;
            $display("FAIL async_reset: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                     cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
        end
        #1;
        sys_rst_n = 1'b1;
        threshold = 16'd3;
        for (int i = 0; i < 2; i++) begin
            evt = (i == 1);
            if (evt) tot_exp++;
            sb.push_back({1'b0, 16'(i), ack_exp, tot_exp});
            tick();
            e = sb.pop_front();
            checks++;
            if (cur !== e) begin
                errors++;
                $display("FAIL reset_resume[%0d]: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                         i, cur.irq, cur.pend, cur.ack, cur.total, e.irq, e.pend, e.ack, e.total);
            end
        end
        evt = 1'b0;
    endtask

    task automatic test_saturation();
        sys_rst_n = 1'b0;
        #1;
        sys_rst_n = 1'b1;
        en = 1'b1; irq_ack = 1'b0; threshold = 16'd15; timeout = 16'd0;
        for (int i = 0; i < 41; i++) begin
            evt = (i < 40);
            sb4.push_back({1'(i >= 14), 4'((i + 1 > 15) ? 15 : i + 1), 4'd0,
                           32'((i < 40) ? i + 1 : 40)});
            tick();
            e4 = sb4.pop_front();
            checks++;
            if (cur4 !== e4) begin
                errors++;
                $display("FAIL saturation[%0d]: got irq=%b pend=%0d ack=%0d total=%0d want irq=%b pend=%0d ack=%0d total=%0d",
                         i, cur4.irq, cur4.pend, cur4.ack, cur4.total, e4.irq, e4.pend, e4.ack, e4.total);
            end
        end
        evt = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        en = 1'b0; evt = 1'b0; irq_ack = 1'b0;
        threshold = '0; timeout = '0;
        #1;
        test_reset();
        #1;
        sys_rst_n = 1'b1;
        test_threshold();
        test_timeout();
        test_en_flush();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
